// File: rtl/shift_arbiter.sv
// shift_arbiter: arbitrates two requesters onto one external 4-bit shifter.
// A granted command loads a registered accumulator, which is then iterated
// through the shifter `steps` times. The final value is returned on a
// valid/ready response port tagged with the id of the issuing requester.
module shift_arbiter #(
    parameter int unsigned STEP_W = 4,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_data,
    input  logic [2:0]        req0_mode,
    input  logic [STEP_W-1:0] req0_steps,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_data,
    input  logic [2:0]        req1_mode,
    input  logic [STEP_W-1:0] req1_steps,
    output logic [3:0]        sh_a,
    output logic [2:0]        sh_mode,
    input  logic [3:0]        sh_r,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [3:0]        rsp_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        acc_q, acc_d;
    logic [2:0]        mode_q, mode_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              id_q, id_d;
    logic              rr_last_q, rr_last_d;

    logic              gnt_any;
    logic              gnt_id;
    logic [3:0]        sel_data;
    logic [2:0]        sel_mode;
    logic [STEP_W-1:0] sel_steps;

    // Grant selection: single valid requester wins; on contention either
    // rotate away from the last winner or give req0 fixed priority.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = RR_EN ? ~rr_last_q : 1'b0;
        end else begin
            gnt_id = req1_valid;
        end
        sel_data  = gnt_id ? req1_data  : req0_data;
        sel_mode  = gnt_id ? req1_mode  : req0_mode;
        sel_steps = gnt_id ? req1_steps : req0_steps;
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mode_q    <= '0;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Next-state, datapath update and requester handshakes.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        rr_last_d  = rr_last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    acc_d      = sel_data;
                    mode_d     = sel_mode;
                    cnt_d      = sel_steps;
                    id_d       = gnt_id;
                    rr_last_d  = gnt_id;
                    state_d    = (sel_steps != '0) ? RUN : RESP;
                end
            end
            RUN: begin
                acc_d = sh_r;
                cnt_d = cnt_q - STEP_W'(1);
                if (cnt_q == STEP_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered values drive the shifter and response port directly.
    always_comb begin
        sh_a      = acc_q;
        sh_mode   = mode_q;
        rsp_valid = (state_q == RESP);
        rsp_id    = id_q;
        rsp_data  = acc_q;
        busy      = (state_q != IDLE);
    end

endmodule
